// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI register-bank peripheral.
package spi_reg_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  // Bits per frame: R/W flag, address field, data field.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a controller (master) and the register bank (slave).
interface spi_reg_bank_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, ncs, copi, input cipo, cipo_oe);
  modport slave  (input sclk, ncs, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall pulse
// generation. Edge pulses are suppressed until the chain and the
// previous-value flop have refilled after reset, so a pin that is already
// at the non-reset level does not produce a phantom edge.
module spi_sync_edge #(
  parameter int   SYNC_LEN = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_LEN-1:0] r_sync;
  logic                r_prev;
  logic [SYNC_LEN:0]   r_settle;

  // Synchroniser chain, previous-value flop and post-reset settle tracker.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_sync   <= {SYNC_LEN{RST_VAL}};
      r_prev   <= RST_VAL;
      r_settle <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_LEN-2:0], i_async};
      r_prev   <= r_sync[SYNC_LEN-1];
      r_settle <= {r_settle[SYNC_LEN-1:0], 1'b1};
    end
  end

  assign o_sync = r_sync[SYNC_LEN-1];
  assign o_rise = r_settle[SYNC_LEN] &  r_sync[SYNC_LEN-1] & ~r_prev;
  assign o_fall = r_settle[SYNC_LEN] & ~r_sync[SYNC_LEN-1] &  r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: frames of {R/W, address, data}, MSB first.
// Writes commit on the final data bit; reads return the register on CIPO.
// Optional build macro SPI_REG_STATUS_EN adds a read-only saturating
// frame-error counter at address NUM_REGS (any write to it clears it).
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 5,
  parameter int SYNC_LEN = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_reg_bank_if.slave                spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int F     = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(F + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LSB = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA0    = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(F - 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W:0]     r_cmd;
  logic [ADDR_W:0]     w_cmd_nxt;
  logic [DATA_W-1:0]   r_din, w_din_nxt;
  logic [DATA_W-1:0]   r_sout, w_rd_word;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_strobe;
  logic                r_frame_err;
  logic                r_cipo_oe;
  logic [SYNC_LEN-1:0] r_copi_sync;
  logic [31:0]         w_lat_addr32, w_wr_addr32;
  logic                w_copi, w_sclk_rise, w_sclk_fall, w_unused_sclk_sync;
  logic                w_ncs_sync, w_ncs_rise, w_ncs_fall;
  logic                w_latch, w_commit, w_abort;

  spi_sync_edge #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi.sclk),
    .o_sync (w_unused_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b1)) u_ncs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi.ncs),
    .o_sync (w_ncs_sync),
    .o_rise (w_ncs_rise),
    .o_fall (w_ncs_fall)
  );

  // COPI needs the same latency as SCLK so data lines up with sclk_rise.
  always_ff @(posedge clk) begin
    if (!rst_n) r_copi_sync <= '0;
    else        r_copi_sync <= {r_copi_sync[SYNC_LEN-2:0], spi.copi};
  end

  assign w_copi       = r_copi_sync[SYNC_LEN-1];
  assign w_cmd_nxt    = (r_cmd << 1) | {{ADDR_W{1'b0}}, w_copi};
  assign w_din_nxt    = (r_din << 1) | {{(DATA_W-1){1'b0}}, w_copi};
  assign w_lat_addr32 = 32'(w_cmd_nxt[ADDR_W-1:0]);
  assign w_wr_addr32  = 32'(r_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus one-cycle latch/commit/abort decisions; the sclk_rise
  // that completes a frame wins over a coincident ncs_rise.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE: if (w_ncs_fall) w_state_nxt = CMD;
      CMD: begin
        if (w_sclk_rise && r_cnt == CNT_ADDR_LSB) begin
          w_latch     = 1'b1;
          w_state_nxt = DATA;
        end
        if (w_ncs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (w_sclk_rise && r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = DONE;
        end
        if (w_ncs_rise) begin
          w_abort     = !w_commit;
          w_state_nxt = IDLE;
        end
      end
      DONE:    if (w_ncs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SPI_REG_STATUS_EN
  logic [DATA_W-1:0] r_status;

  // Saturating frame-error counter; a write to its address clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_status <= '0;
    else if (w_commit && !r_rd && w_wr_addr32 == NUM_REGS)
      r_status <= '0;
    else if (w_abort && r_status != '1)
      r_status <= r_status + DATA_W'(1);
  end
`endif

  // Read mux keyed on the address being latched; unmapped addresses read 0.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_lat_addr32 == 32'(k)) w_rd_word = r_regs[k];
`ifdef SPI_REG_STATUS_EN
    if (w_lat_addr32 == NUM_REGS) w_rd_word = r_status;
`endif
  end

  // Frame datapath: bit counter, shift registers, register file, pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register file is a handful of flops driving the top level,
      // so it is reset explicitly rather than treated as uninitialised RAM.
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_din       <= '0;
      r_sout      <= '0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wr_strobe <= '0;
      r_frame_err <= 1'b0;
      r_cipo_oe   <= 1'b0;
    end else begin
      r_wr_strobe <= '0;
      r_frame_err <= w_abort;
      r_cipo_oe   <= !w_ncs_sync && (w_state_nxt != IDLE);

      if (r_state == IDLE && w_ncs_fall)
        r_cnt <= '0;
      else if ((r_state == CMD || r_state == DATA) && w_sclk_rise)
        r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == CMD && w_sclk_rise)  r_cmd <= w_cmd_nxt;
      if (r_state == DATA && w_sclk_rise) r_din <= w_din_nxt;

      // The first data bit must stay on CIPO until the first data-phase
      // rise, so shifting starts only after a data bit has been sampled.
      if (w_latch) begin
        r_rd   <= !w_cmd_nxt[ADDR_W];
        r_addr <= w_cmd_nxt[ADDR_W-1:0];
        r_sout <= w_rd_word;
      end else if (r_state == DATA && r_rd && w_sclk_fall && r_cnt > CNT_DATA0) begin
        r_sout <= r_sout << 1;
      end

      if (w_commit && !r_rd) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_wr_addr32 == 32'(k)) begin
            r_regs[k]      <= w_din_nxt;
            r_wr_strobe[k] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
  end

  assign wr_strobe   = r_wr_strobe;
  assign frame_err   = r_frame_err;
  assign spi.cipo_oe = r_cipo_oe;
  assign spi.cipo    = (r_state == DATA) && r_rd && r_sout[DATA_W-1];

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI mode-0 register-bank peripheral.
- Drives the output-enable, PWM-enable and duty-cycle registers for the top level.
- Generalises the current write-only 5x8 block:
  - configurable address width, data width and register count;
  - read-back over CIPO;
  - single-clock sampling with explicit SCLK edge detection;
  - frame-abort detection.
- All logic runs on clk; SPI pins are asynchronous inputs.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, register and data field width in bits
NUM_REGS, 5, number of implemented registers (1..2^ADDR_W, minus 1 when SPI_REG_STATUS_EN is defined)
SYNC_LEN, 2, synchroniser flops per SPI input (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
sclk  in  1  SPI clock, asynchronous
ncs  in  1  chip select, active low, asynchronous
copi  in  1  controller-out data, asynchronous
cipo  out  1  peripheral-out data
cipo_oe  out  1  CIPO output enable (1 while selected)
regs_o  out  NUM_REGS*DATA_W  register file; register k at [k*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-cycle pulse per register on commit
frame_err  out  1  one-cycle pulse on aborted frame

Behaviour:
- Reset: synchronous active-low, one clock, one reset style only. All of the following clear:
  - regs_o, wr_strobe, frame_err, cipo, cipo_oe = 0;
  - synchronisers = 0; ncs synchroniser = 1;
  - state = IDLE.
- Input path:
  - sclk, ncs and copi each pass through a SYNC_LEN-flop synchroniser.
  - A prev-value flop on synced sclk and ncs produces the pulses sclk_rise, sclk_fall, ncs_fall and ncs_rise.
  - Input-to-edge-pulse latency is SYNC_LEN+1 clk.
  - SCLK high and low phases must each be >= SYNC_LEN+2 clk; shorter phases are unsupported.
- Frame format, MSB first: R/W bit (1 = write), then ADDR_W address bits, then DATA_W data bits. Frame length F = 1+ADDR_W+DATA_W (16 at defaults).
- COPI is sampled on sclk_rise only while synced ncs = 0.
- State machine:
  - IDLE: on ncs_fall, clear the bit counter and go to CMD. cipo_oe = 1 whenever synced ncs = 0.
  - CMD: shift in R/W and address.
    - When the address LSB is sampled, latch rw and addr.
    - For a read, load the shift-out register with reg[addr], or 0 if addr >= NUM_REGS.
    - Go to DATA.
  - DATA:
    - Shift in data bits.
    - For a read, cipo presents shift-out MSB continuously; the register shifts left on each sclk_fall.
    - On the sclk_rise that samples the final data bit, go to DONE.
    - For a write with addr < NUM_REGS: reg[addr] <= data, and wr_strobe[addr] pulses on the following clk.
    - Writes to out-of-range addresses are dropped with no strobe.
    - Read frames never modify registers.
  - DONE: ignore extra SCLK edges; cipo = 0; on ncs_rise go to IDLE.
- Abort: ncs_rise while in CMD or DATA returns to IDLE with no commit and pulses frame_err for one clk. ncs_rise in DONE is normal.
- Simultaneous events: an ncs_rise on the same clk as the final sclk_rise counts as a completed frame (commit, no error). The sclk_rise is processed first.
- Reset mid-frame: the frame is discarded, registers clear, and the next frame needs a fresh ncs_fall.
- Bit counter width is $clog2(F+1); it never wraps within a frame.
- In IDLE: cipo = 0, cipo_oe = 0.

Optional Feature:
- Macro: SPI_REG_STATUS_EN.
- When defined:
  - A read-only status register is placed at address NUM_REGS.
  - Contents: DATA_W-bit saturating count of frame_err events; it sticks at all-ones.
  - Reads return the count.
  - A write to address NUM_REGS clears the count, regardless of data; there is no wr_strobe bit for it.
- When undefined: address NUM_REGS is out of range. Reads return 0 and writes are dropped.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum {IDLE, CMD, DATA, DONE};
  - a frame-length function F(ADDR_W, DATA_W);
  - the defaults for ADDR_W and DATA_W.
- One sub-module, spi_sync_edge: synchroniser plus edge detector, instantiated for sclk and ncs. copi uses a synchroniser only.

Test Plan:
- Write 0x80 to addr 0x04 (frame 0x8480) -> regs_o[39:32] = 0x80, wr_strobe = 5'b10000 for one clk, other registers 0.
- Write 0xA5 to addr 0x02, then read addr 0x02 (frame 0x0200) -> cipo shifts 1,0,1,0,0,1,0,1 in the data phase; regs_o unchanged.
- Write to addr 0x30 (out of range) -> no strobe, regs unchanged. Read addr 0x30 -> all-zero data.
- Abort: ncs rises after 10 SCLK bits -> frame_err pulses once, no register change. The next full frame writes correctly.
- Send 20 SCLK edges in one frame writing 0x3C to addr 0x01 -> reg1 = 0x3C, extra bits ignored, no frame_err.
- SPI_REG_STATUS_EN: 3 aborts, then read addr 5 -> 0x03. Write addr 5 -> next read returns 0x00.
